registro_banco_universal: RTL and testbench

REGISTRO_BANCO_UNIVERSAL -- requirements
Module: registro_banco_universal

---
 rtl/registro_banco_universal.sv | 146 ++++++++++++++
 tb/tb_registro_banco_universal.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/registro_banco_universal.sv
// registro_banco_universal
//    Bank of CH registers, N bits each, fed from one of two parallel sources
//    (RTC or counter). Registers either track the source, hold, take a direct
//    write, or take an atomic snapshot: the source is sampled into a shadow
//    buffer and committed only once two consecutive samples agree. After
//    MAX_RETRY disagreements the latest sample is committed anyway and err is
//    raised.
//    All state updates on the falling edge of clk; reset is synchronous.
//
// Ports
//    clk, reset        clock (falling edge active), synchronous active-high reset
//    hold              1 freezes tracking
//    chip_select       source select: 0 = in_rtc_dato, 1 = in_count_dato
//    in_rtc_dato       RTC data, channel i at [i*N +: N]
//    in_count_dato     counter data, same packing
//    snap_req          atomic snapshot request (accepted only while hold=1)
//    wr_en/wr_addr/wr_dato  direct channel write (out-of-range addr ignored)
//    rd_addr/out_dato  combinational channel read (out-of-range reads 0)
//    out_bus           all channels
//    busy              snapshot compare in progress
//    done              one-cycle pulse on snapshot commit
//    err               last snapshot was forced after MAX_RETRY mismatches
//    changed           per-channel one-cycle pulse when a channel's value changes
module registro_banco_universal #(
   parameter int unsigned N         = 8,
   parameter int unsigned CH        = 4,
   parameter int unsigned AW        = 2,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            hold,
   input  logic            chip_select,
   input  logic [CH*N-1:0] in_rtc_dato,
   input  logic [CH*N-1:0] in_count_dato,
   input  logic            snap_req,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [N-1:0]    wr_dato,
   input  logic [AW-1:0]   rd_addr,
   output logic [N-1:0]    out_dato,
   output logic [CH*N-1:0] out_bus,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [CH-1:0]   changed
);

   localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   typedef enum logic {
      IDLE,
      CHECK
   } state_t;

   state_t            state, state_nxt;
   logic [CH*N-1:0]   src;
   logic [CH*N-1:0]   bank, bank_nxt;
   logic [CH*N-1:0]   shadow, shadow_nxt;
   logic [RW-1:0]     retry, retry_nxt;
   logic              err_nxt;
   logic              commit;
   logic [CH-1:0]     changed_nxt;

   // Snapshot control and per-channel next value
   always_comb begin
      src         = chip_select ? in_count_dato : in_rtc_dato;
      state_nxt   = state;
      shadow_nxt  = shadow;
      retry_nxt   = retry;
      err_nxt     = err;
      commit      = 1'b0;
      bank_nxt    = bank;
      changed_nxt = '0;

      case (state)
         IDLE: begin
            if (snap_req && hold) begin
               shadow_nxt = src;
               retry_nxt  = '0;
               err_nxt    = 1'b0;
               state_nxt  = CHECK;
            end
         end
         CHECK: begin
            if (!hold) begin
               // abort: tracking resumes through the !hold path below
               state_nxt = IDLE;
            end else if (src == shadow) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end else if (retry < RETRY_LIMIT) begin
               shadow_nxt = src;
               retry_nxt  = retry + 1'b1;
            end else begin
               commit    = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // write > commit > tracking > retain; commit and tracking both load src
      for (int unsigned i = 0; i < CH; i++) begin
         if (wr_en && (wr_addr == AW'(i)))
            bank_nxt[i*N +: N] = wr_dato;
         else if (commit || !hold)
            bank_nxt[i*N +: N] = src[i*N +: N];
         changed_nxt[i] = (bank_nxt[i*N +: N] != bank[i*N +: N]);
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bank    <= '0;
         shadow  <= '0;
         retry   <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
         changed <= '0;
      end else begin
         state   <= state_nxt;
         bank    <= bank_nxt;
         shadow  <= shadow_nxt;
         retry   <= retry_nxt;
         err     <= err_nxt;
         done    <= commit;
         changed <= changed_nxt;
      end
   end

   always_comb begin
      out_dato = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (rd_addr == AW'(i))
            out_dato = bank[i*N +: N];
      end
   end

   assign out_bus = bank;
   assign busy    = (state == CHECK);

endmodule

// File: tb/tb_registro_banco_universal.sv
// tb_registro_banco_universal
//    Directed scenarios followed by randomized traffic, every cycle compared
//    against a behavioural model of the register bank.
module tb_registro_banco_universal;

   localparam int NB  = 8;
   localparam int NCH = 4;
   localparam int AWB = 3;
   localparam int MR  = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             hold = 1'b0;
   logic             chip_select = 1'b0;
   logic [NCH*NB-1:0] in_rtc_dato = '0;
   logic [NCH*NB-1:0] in_count_dato = '0;
   logic             snap_req = 1'b0;
   logic             wr_en = 1'b0;
   logic [AWB-1:0]   wr_addr = '0;
   logic [NB-1:0]    wr_dato = '0;
   logic [AWB-1:0]   rd_addr = '0;
   logic [NB-1:0]    out_dato;
   logic [NCH*NB-1:0] out_bus;
   logic             busy, done, err;
   logic [NCH-1:0]   changed;

   registro_banco_universal #(.N(NB), .CH(NCH), .AW(AWB), .MAX_RETRY(MR)) dut (
      .clk(clk), .reset(reset), .hold(hold), .chip_select(chip_select),
      .in_rtc_dato(in_rtc_dato), .in_count_dato(in_count_dato),
      .snap_req(snap_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dato(wr_dato),
      .rd_addr(rd_addr), .out_dato(out_dato), .out_bus(out_bus),
      .busy(busy), .done(done), .err(err), .changed(changed)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: channels as an array, snapshot as "pending" plus counters
   logic [NB-1:0]     m_chan [NCH];
   logic [NCH*NB-1:0] m_shadow;
   bit                m_pending;
   int                m_tries;
   bit                m_err, m_done;
   bit [NCH-1:0]      m_changed;

   task automatic model_edge();
      logic [NCH*NB-1:0] s;
      bit take;
      logic [NB-1:0] v;
      if (reset) begin
         foreach (m_chan[k]) m_chan[k] = '0;
         m_shadow = '0; m_pending = 0; m_tries = 0;
         m_err = 0; m_done = 0; m_changed = '0;
         return;
      end
      s = chip_select ? in_count_dato : in_rtc_dato;
      take = 0;
      if (!m_pending) begin
         if (snap_req && hold) begin
            m_shadow = s; m_tries = 0; m_err = 0; m_pending = 1;
         end
      end else if (!hold) begin
         m_pending = 0;
      end else if (s == m_shadow) begin
         take = 1; m_pending = 0;
      end else if (m_tries < MR) begin
         m_shadow = s; m_tries++;
      end else begin
         take = 1; m_err = 1; m_pending = 0;
      end
      m_done = take;
      for (int k = 0; k < NCH; k++) begin
         v = m_chan[k];
         if (wr_en && int'(wr_addr) == k) m_chan[k] = wr_dato;
         else if (take || !hold)         m_chan[k] = s[k*NB +: NB];
         m_changed[k] = (v != m_chan[k]);
      end
   endtask

   function automatic logic [NCH*NB-1:0] m_bus();
      logic [NCH*NB-1:0] b;
      for (int k = 0; k < NCH; k++) b[k*NB +: NB] = m_chan[k];
      return b;
   endfunction

   task automatic step();
      logic [NB-1:0] rd_exp;
      @(negedge clk);
      model_edge();
      #2;
      rd_exp = (int'(rd_addr) < NCH) ? m_chan[rd_addr[1:0]] : '0;
      chk("out_bus", out_bus, m_bus());
      chk("busy", busy, m_pending);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("changed", changed, m_changed);
      chk("out_dato", out_dato, rd_exp);
   endtask

   initial begin
      // reset
      step();
      chk("rst_bus", out_bus, 32'h0);
      chk("rst_busy", busy, 1'b0);

      // tracking from both sources
      reset = 1'b0; hold = 1'b0; chip_select = 1'b0;
      in_rtc_dato = 32'h0000_0015; in_count_dato = 32'h0000_0042;
      step();
      chk("trk_rtc", out_bus[7:0], 8'h15);
      chk("trk_chg", changed[0], 1'b1);
      chip_select = 1'b1;
      step();
      chk("trk_cnt", out_bus[7:0], 8'h42);
      step();
      chk("trk_chg_clr", changed, 4'h0);

      // stable snapshot
      hold = 1'b1; chip_select = 1'b0; in_rtc_dato = 32'h1234_5678; snap_req = 1'b1;
      step();
      chk("stab_busy", busy, 1'b1);
      chk("stab_held", out_bus, 32'h0000_0042);
      snap_req = 1'b0;
      step();
      chk("stab_done", done, 1'b1);
      chk("stab_bus", out_bus, 32'h1234_5678);
      chk("stab_err", err, 1'b0);
      step();
      chk("stab_pulse", done, 1'b0);

      // unstable snapshot: forced commit on 5th edge
      snap_req = 1'b1; in_rtc_dato = 32'hA000_0001;
      step();
      snap_req = 1'b0;
      for (int e = 2; e <= 5; e++) begin
         in_rtc_dato = in_rtc_dato + 32'h0101_0101;
         step();
         if (e < 5) chk("unst_wait", {busy, done}, 2'b10);
      end
      chk("unst_done", done, 1'b1);
      chk("unst_err", err, 1'b1);
      chk("unst_bus", out_bus, in_rtc_dato);

      // write beats commit on the commit edge; out-of-range write ignored
      in_rtc_dato = 32'h1122_3344; snap_req = 1'b1;
      step();
      chk("wr_err_clr", err, 1'b0);
      snap_req = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_dato = 8'hA5; rd_addr = 3'd2;
      step();
      chk("wr_bus", out_bus, 32'h11A5_3344);
      chk("wr_rd", out_dato, 8'hA5);
      wr_addr = 3'd5; wr_dato = 8'hFF; rd_addr = 3'd6;
      step();
      chk("wr_oor", out_bus, 32'h11A5_3344);
      chk("rd_oor", out_dato, 8'h00);
      wr_en = 1'b0;

      // abort by dropping hold, then reset mid-snapshot
      in_rtc_dato = 32'h5566_7788; snap_req = 1'b1;
      step();
      snap_req = 1'b0; hold = 1'b0; in_rtc_dato = 32'h99AA_BBCC;
      step();
      chk("abort_done", {busy, done}, 2'b00);
      chk("abort_trk", out_bus, 32'h99AA_BBCC);
      hold = 1'b1; snap_req = 1'b1;
      step();
      chk("rst_mid_busy", busy, 1'b1);
      snap_req = 1'b0; reset = 1'b1; in_rtc_dato = 32'h0102_0304;
      step();
      chk("rst_mid", {out_bus, busy, done, err, changed}, 39'h0);
      reset = 1'b0;

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 99) < 2);
         hold        = ($urandom_range(0, 99) < 80);
         snap_req    = ($urandom_range(0, 99) < 25);
         wr_en       = ($urandom_range(0, 99) < 15);
         wr_addr     = AWB'($urandom_range(0, 7));
         wr_dato     = NB'($urandom);
         rd_addr     = AWB'($urandom_range(0, 7));
         if ($urandom_range(0, 99) < 10) chip_select = ~chip_select;
         if ($urandom_range(0, 99) < 30) in_rtc_dato   = $urandom;
         if ($urandom_range(0, 99) < 30) in_count_dato = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
